// File: rtl/rep_seq_pkg.sv
// Shared types and widths for the repeated-sequence monitor.
package rep_seq_pkg;

  localparam int unsigned OCC_W  = 4;
  localparam int unsigned WDOG_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CHECK = 2'd2,
    WAIT  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_GOTO   = 1'b0,
    MODE_NONCON = 1'b1
  } mode_e;

  // Where a check goes once the required number of b occurrences is reached.
  function automatic state_e done_state(input mode_e m);
    return (m == MODE_GOTO) ? CHECK : WAIT;
  endfunction

endpackage

// File: rtl/rep_seq_edge.sv
// Trigger edge detector: combinational rise strobe plus registered drop pulse
// for triggers that arrive while a check is already running.
module rep_seq_edge (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic busy,
  output logic rose_c,
  output logic drop
);

  logic a_q;

  assign rose_c = a & ~a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= 1'b0;
      drop <= 1'b0;
    end else begin
      a_q  <= a;
      drop <= rose_c & busy;
    end
  end

endmodule

// File: rtl/rep_seq_monitor.sv
// Repeated-sequence monitor: after a trigger, checks b[->REPS] ##1 b (goto)
// or b[=REPS] ##1 b (non-consecutive). Optional watchdog: REP_SEQ_MONITOR_TIMEOUT_EN.
module rep_seq_monitor
  import rep_seq_pkg::*;
#(
  parameter int unsigned REPS    = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             mode,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             tmo,
  output logic             drop,
  output logic [OCC_W-1:0] occ
);

  localparam logic [OCC_W-1:0] REPS_V = OCC_W'(REPS);

  if (REPS < 1 || REPS > 15) begin : g_bad_reps
    $error("rep_seq_monitor: REPS must be within 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rep_seq_monitor: TIMEOUT must be within 2..255");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_inc;
  logic             pass_d, fail_d;
  logic             rose_c;

  rep_seq_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .busy   (busy),
    .rose_c (rose_c),
    .drop   (drop)
  );

  assign occ_inc = occ + OCC_W'(1);

`ifdef REP_SEQ_MONITOR_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] TIMEOUT_V = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              tmo_d;
`endif

  // Next-state, occurrence count and result decisions.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    occ_d   = occ;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
`ifdef REP_SEQ_MONITOR_TIMEOUT_EN
    wdog_d  = wdog_q;
    tmo_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rose_c) begin
          mode_d = mode_e'(mode);
          // The trigger cycle itself counts, as in an overlapping implication.
          occ_d  = OCC_W'(b);
          if (b && (REPS_V == OCC_W'(1))) begin
            state_d = done_state(mode_e'(mode));
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (b) begin
          occ_d = occ_inc;
          if (occ_inc == REPS_V) begin
            state_d = done_state(mode_q);
          end
        end
      end
      CHECK: begin
        pass_d  = b;
        fail_d  = ~b;
        state_d = IDLE;
      end
      WAIT: begin
        if (b) begin
          pass_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef REP_SEQ_MONITOR_TIMEOUT_EN
    // Watchdog counts cycles since the trigger; a legitimate pass wins a tie.
    if (state_q == IDLE) begin
      if (rose_c) begin
        wdog_d = '0;
      end
    end else if (wdog_q != '1) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    if (((state_q == COUNT) || (state_q == WAIT)) && !pass_d && (wdog_d >= TIMEOUT_V)) begin
      fail_d  = 1'b1;
      tmo_d   = 1'b1;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_GOTO;
      occ     <= '0;
      busy    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      occ     <= occ_d;
      busy    <= (state_d != IDLE);
      pass    <= pass_d;
      fail    <= fail_d;
    end
  end

`ifdef REP_SEQ_MONITOR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      tmo    <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo    <= tmo_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_rep_seq_monitor.sv
// Self-checking bench for rep_seq_monitor: a per-check sample-history model
// compared every cycle, plus hand-computed expectations for directed scenarios.
module tb_rep_seq_monitor;
  import rep_seq_pkg::*;

  localparam int unsigned REPS    = 3;
  localparam int unsigned TIMEOUT = 16;

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             a    = 1'b0;
  logic             b    = 1'b0;
  logic             mode = 1'b0;
  logic             busy, pass, fail, tmo, drop;
  logic [OCC_W-1:0] occ;

  int tests = 0;
  int fails = 0;

  rep_seq_monitor #(.REPS(REPS), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .mode (mode),
    .busy (busy),
    .pass (pass),
    .fail (fail),
    .tmo  (tmo),
    .drop (drop),
    .occ  (occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: remembers every b sample of the current check and derives the
  // outcome from counting occurrences in that history.
  bit m_aq, m_active, m_mode;
  bit m_pass, m_fail, m_tmo, m_drop;
  int m_occ;
  bit m_samp[$];

  task automatic model_step(input logic ra, input logic rb, input logic rm, input logic rr);
    bit rose, done;
    int ones, k, last;
    m_pass = 0; m_fail = 0; m_tmo = 0; m_drop = 0;
    if (rr) begin
      m_aq = 0; m_active = 0; m_occ = 0; m_samp.delete();
      return;
    end
    rose   = ra && !m_aq;
    m_aq   = ra;
    m_drop = rose && m_active;
    if (!m_active) begin
      if (!rose) return;
      m_active = 1;
      m_mode   = rm;
      m_samp.delete();
    end
    m_samp.push_back(rb);
    last = m_samp.size() - 1;
    ones = 0;
    k    = -1;
    for (int j = 0; j <= last; j++) begin
      if (m_samp[j]) ones++;
      if (ones == int'(REPS) && k < 0) k = j;
    end
    m_occ = (ones > int'(REPS)) ? int'(REPS) : ones;
    done  = 0;
    if (k >= 0 && last > k) begin
      if (!m_mode) begin
        if (last == k + 1) begin
          done = 1; m_pass = rb; m_fail = !rb;
        end
      end else if (rb) begin
        done = 1; m_pass = 1;
      end
    end
`ifdef REP_SEQ_MONITOR_TIMEOUT_EN
    if (!done && last >= int'(TIMEOUT)) begin
      done = 1; m_fail = 1; m_tmo = 1;
    end
`endif
    if (done) m_active = 0;
  endtask

  always @(posedge clk) begin : cmp
    model_step(a, b, mode, rst);
    #1;
    chk("cyc_busy", 8'(busy), 8'(m_active));
    chk("cyc_pass", 8'(pass), 8'(m_pass));
    chk("cyc_fail", 8'(fail), 8'(m_fail));
    chk("cyc_tmo",  8'(tmo),  8'(m_tmo));
    chk("cyc_drop", 8'(drop), 8'(m_drop));
    chk("cyc_occ",  8'(occ),  8'(m_occ));
  end

  // Drive one cycle's inputs, then return just after that posedge.
  task automatic step(input logic va, input logic vb);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle(2);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_occ",  8'(occ),  8'd0);
    chk("rst_pass", 8'(pass), 8'd0);
    rst = 1'b0;
    idle(2);

    // Goto mode, b high from the trigger cycle: pass after CHECK.
    mode = 1'b0;
    step(1, 1); chk("g_occ_e0", 8'(occ), 8'd1);
    step(0, 1); chk("g_occ_e1", 8'(occ), 8'd2);
    step(0, 1); chk("g_occ_e2", 8'(occ), 8'd3); chk("g_busy_e2", 8'(busy), 8'd1);
    step(0, 1); chk("g_pass_e3", 8'(pass), 8'd1); chk("g_fail_e3", 8'(fail), 8'd0);
                chk("g_occ_hold", 8'(occ), 8'd3);
    step(0, 0); chk("g_pass_e4", 8'(pass), 8'd0); chk("g_busy_e4", 8'(busy), 8'd0);
    idle(2);

    // Goto mode, third b followed by b=0: fail.
    step(1, 0); chk("gf_occ_e0", 8'(occ), 8'd0);
    step(0, 1); step(0, 1);
    step(0, 1); chk("gf_occ_e3", 8'(occ), 8'd3);
    step(0, 0); chk("gf_fail_e4", 8'(fail), 8'd1); chk("gf_pass_e4", 8'(pass), 8'd0);
                chk("gf_tmo_e4", 8'(tmo), 8'd0);
    idle(2);

    // Non-consecutive mode: gap tolerated, pass on the next b.
    mode = 1'b1;
    step(1, 0);
    for (int i = 1; i <= 3; i++) step(0, 1);
    for (int i = 4; i <= 8; i++) step(0, 0);
    chk("n_busy_e8", 8'(busy), 8'd1);
    step(0, 1); chk("n_pass_e9", 8'(pass), 8'd1); chk("n_busy_e9", 8'(busy), 8'd0);
                chk("n_occ_e9", 8'(occ), 8'd3);
    idle(2);

    // Non-consecutive mode with b never returning: watchdog or indefinite wait.
    step(1, 0);
    for (int i = 1; i <= 3; i++) step(0, 1);
`ifdef REP_SEQ_MONITOR_TIMEOUT_EN
    for (int i = 4; i <= 15; i++) step(0, 0);
    chk("t_busy_e15", 8'(busy), 8'd1); chk("t_fail_e15", 8'(fail), 8'd0);
    step(0, 0);
    chk("t_fail_e16", 8'(fail), 8'd1); chk("t_tmo_e16", 8'(tmo), 8'd1);
    chk("t_busy_e16", 8'(busy), 8'd0);
    idle(2);
`else
    for (int i = 4; i <= 40; i++) step(0, 0);
    chk("t_busy_e40", 8'(busy), 8'd1); chk("t_tmo_e40", 8'(tmo), 8'd0);
    rst = 1'b1;
    step(0, 0);
    chk("t_rst_busy", 8'(busy), 8'd0);
    rst = 1'b0;
    idle(2);
`endif

    // Second trigger during a check is dropped; count continues.
    mode = 1'b0;
    step(1, 1);
    step(0, 0);
    step(1, 1); chk("d_drop_e2", 8'(drop), 8'd1); chk("d_occ_e2", 8'(occ), 8'd2);
                chk("d_busy_e2", 8'(busy), 8'd1);
    step(0, 1); chk("d_drop_e3", 8'(drop), 8'd0); chk("d_occ_e3", 8'(occ), 8'd3);
    step(0, 1); chk("d_pass_e4", 8'(pass), 8'd1);
    idle(2);

    // Trigger coincident with the return to IDLE is dropped, no new check.
    step(1, 1); step(0, 1); step(0, 1);
    step(1, 1); chk("r_pass_e3", 8'(pass), 8'd1); chk("r_drop_e3", 8'(drop), 8'd1);
                chk("r_busy_e3", 8'(busy), 8'd0);
    step(1, 0); chk("r_busy_e4", 8'(busy), 8'd0); chk("r_drop_e4", 8'(drop), 8'd0);
    idle(2);

    // Reset mid-check aborts without any result pulse.
    step(1, 1); step(0, 1);
    rst = 1'b1;
    step(0, 1); chk("x_busy_e2", 8'(busy), 8'd0); chk("x_occ_e2", 8'(occ), 8'd0);
    rst = 1'b0;
    step(0, 1); chk("x_pass_e3", 8'(pass), 8'd0); chk("x_fail_e3", 8'(fail), 8'd0);
    step(0, 1); chk("x_pass_e4", 8'(pass), 8'd0); chk("x_busy_e4", 8'(busy), 8'd0);
    idle(2);

    // Mixed stretch checked only by the model.
    for (int i = 0; i < 300; i++) begin
      mode = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 39) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
